// File: rtl/game_pkg.sv
// Shared phase encodings and screen/button geometry for the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        PH_MENU      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_PLAY      = 3'd2,
        PH_GAMEOVER  = 3'd3,
        PH_PAUSE     = 3'd4
    } phase_e;

    localparam int COORD_W = 12;

    localparam logic [COORD_W-1:0] SCREEN_W   = 12'd1024;
    localparam logic [COORD_W-1:0] SCREEN_H   = 12'd768;

    localparam logic [COORD_W-1:0] PLAY_X_MIN = 12'd384;
    localparam logic [COORD_W-1:0] PLAY_X_MAX = 12'd690;
    localparam logic [COORD_W-1:0] PLAY_Y_MIN = 12'd384;
    localparam logic [COORD_W-1:0] PLAY_Y_MAX = 12'd480;

    // Lower region edges are exclusive, upper edges inclusive.
    function automatic logic in_play_btn(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
        return (x > PLAY_X_MIN) && (x <= PLAY_X_MAX) &&
               (y > PLAY_Y_MIN) && (y <= PLAY_Y_MAX) &&
               (x < SCREEN_W)   && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debouncer: the output follows the raw button only
// after the synchronised level has held for DEBOUNCE_CYC consecutive cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 650000
) (
    input  logic pclk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    sync_q;
    logic          cand_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;

    // Any change of the candidate level reloads the down-counter.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_q   <= '0;
            cand_q   <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (sync_q[1] != cand_q) begin
                cand_q <= sync_q[1];
                cnt_q  <= CNT_LOAD;
            end else if (cand_q != stable_q) begin
                if (cnt_q <= CNT_ONE) begin
                    stable_q <= cand_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q - CNT_ONE;
                end
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/game_phase_ctl.sv
// Game sequencer MENU -> COUNTDOWN -> PLAY -> GAME_OVER -> MENU with pattern
// scheduling; optional PAUSE phase is built only when GAME_PAUSE_EN is defined.
module game_phase_ctl
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNTDOWN_SEC  = 3,
    parameter int ROUND_SEC      = 20,
    parameter int GAMEOVER_SEC   = 5,
    parameter int NUM_PATTERNS   = 4,
    parameter int DEBOUNCE_CYC   = 650000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        mouse_left,
    input  logic        btn_menu,
    input  logic        btn_pause,
    input  logic        player_hit,
    output logic        game_on,
    output logic        menu_on,
    output logic [2:0]  phase,
    output logic [1:0]  countdown,
    output logic [1:0]  pattern_sel,
    output logic [7:0]  rounds_cleared
);

    localparam int FW      = $clog2(FRAMES_PER_SEC + 1);
    localparam int SEC_MAX = (ROUND_SEC > GAMEOVER_SEC) ? ROUND_SEC : GAMEOVER_SEC;
    localparam int SW      = $clog2(SEC_MAX + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
    localparam logic [SW-1:0] ROUND_LAST = SW'(ROUND_SEC - 1);
    localparam logic [SW-1:0] GO_LAST    = SW'(GAMEOVER_SEC - 1);
    localparam logic [1:0]    CD_INIT    = 2'(COUNTDOWN_SEC);
    localparam logic [1:0]    PAT_LAST   = 2'(NUM_PATTERNS - 1);

    phase_e          phase_q, phase_d;
    logic [1:0]      cd_q, cd_d;
    logic [1:0]      pat_q, pat_d;
    logic [7:0]      rounds_q, rounds_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [SW-1:0]   sec_q, sec_d;
    logic            game_on_q, game_on_d;
    logic            menu_on_q, menu_on_d;
    logic            vsync_q, mouse_q, menu_deb_q;
    logic            menu_deb;
    logic            frame_tick, frame_adv, sec_tick, click, menu_req, restart;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_menu_deb (
        .pclk     (pclk),
        .rst      (rst),
        .raw_i    (btn_menu),
        .stable_o (menu_deb)
    );

`ifdef GAME_PAUSE_EN
    logic pause_deb, pause_deb_q, pause_req;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pause_deb (
        .pclk     (pclk),
        .rst      (rst),
        .raw_i    (btn_pause),
        .stable_o (pause_deb)
    );

    always_ff @(posedge pclk) begin
        if (rst) pause_deb_q <= 1'b0;
        else     pause_deb_q <= pause_deb;
    end

    assign pause_req = pause_deb & ~pause_deb_q;
    // Timers stand still while paused so PLAY resumes exactly where it left off.
    assign frame_adv = frame_tick & (phase_q != PH_PAUSE);
`else
    logic unused_btn_pause;
    assign unused_btn_pause = btn_pause;
    assign frame_adv        = frame_tick;
`endif

    assign frame_tick = vsync_in & ~vsync_q;
    assign click      = mouse_left & ~mouse_q;
    assign menu_req   = menu_deb & ~menu_deb_q;
    assign sec_tick   = frame_adv & (frame_q == FRAME_LAST);

    always_comb begin
        phase_d   = phase_q;
        cd_d      = cd_q;
        pat_d     = pat_q;
        rounds_d  = rounds_q;
        sec_d     = sec_q;
        frame_d   = frame_q;
        game_on_d = 1'b0;
        menu_on_d = 1'b0;
        restart   = 1'b0;

        case (phase_q)
            PH_MENU: begin
                if (click && in_play_btn(xpos, ypos)) begin
                    phase_d   = PH_COUNTDOWN;
                    cd_d      = CD_INIT;
                    pat_d     = '0;
                    rounds_d  = '0;
                    game_on_d = 1'b1;
                end
            end
            PH_COUNTDOWN: begin
                if (sec_tick) begin
                    if (cd_q == 2'd1) begin
                        phase_d = PH_PLAY;
                        cd_d    = '0;
                    end else begin
                        cd_d = cd_q - 2'd1;
                    end
                end
            end
            PH_PLAY: begin
                if (player_hit) begin
                    phase_d = PH_GAMEOVER;
`ifdef GAME_PAUSE_EN
                end else if (pause_req) begin
                    phase_d = PH_PAUSE;
`endif
                end else if (sec_tick) begin
                    if (sec_q == ROUND_LAST) begin
                        sec_d = '0;
                        pat_d = (pat_q == PAT_LAST) ? 2'd0 : pat_q + 2'd1;
                        if (rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end
            end
            PH_GAMEOVER: begin
                if (click || (sec_tick && sec_q == GO_LAST)) begin
                    phase_d   = PH_MENU;
                    menu_on_d = 1'b1;
                end else if (sec_tick) begin
                    sec_d = sec_q + SW'(1);
                end
            end
`ifdef GAME_PAUSE_EN
            PH_PAUSE: begin
                if (pause_req) phase_d = PH_PLAY;
            end
`endif
            default: phase_d = PH_MENU;
        endcase

        // Board menu button overrides everything outside MENU.
        if (menu_req && phase_q != PH_MENU) begin
            phase_d   = PH_MENU;
            menu_on_d = 1'b1;
            game_on_d = 1'b0;
            cd_d      = '0;
            pat_d     = pat_q;
            rounds_d  = rounds_q;
            sec_d     = sec_q;
        end

`ifdef GAME_PAUSE_EN
        restart = (phase_d != phase_q) &&
                  !((phase_q == PH_PLAY  && phase_d == PH_PAUSE) ||
                    (phase_q == PH_PAUSE && phase_d == PH_PLAY));
`else
        restart = (phase_d != phase_q);
`endif

        if (restart) begin
            sec_d   = '0;
            frame_d = '0;
        end else if (frame_adv) begin
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q    <= PH_MENU;
            cd_q       <= '0;
            pat_q      <= '0;
            rounds_q   <= '0;
            frame_q    <= '0;
            sec_q      <= '0;
            game_on_q  <= 1'b0;
            menu_on_q  <= 1'b0;
            vsync_q    <= 1'b0;
            mouse_q    <= 1'b0;
            menu_deb_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            cd_q       <= cd_d;
            pat_q      <= pat_d;
            rounds_q   <= rounds_d;
            frame_q    <= frame_d;
            sec_q      <= sec_d;
            game_on_q  <= game_on_d;
            menu_on_q  <= menu_on_d;
            vsync_q    <= vsync_in;
            mouse_q    <= mouse_left;
            menu_deb_q <= menu_deb;
        end
    end

    assign phase          = phase_q;
    assign countdown      = cd_q;
    assign pattern_sel    = pat_q;
    assign rounds_cleared = rounds_q;
    assign game_on        = game_on_q;
    assign menu_on        = menu_on_q;

endmodule

// File: tb/tb_game_phase_ctl.sv
// Directed bench for game_phase_ctl with short timers (2 frames/s, 2 s rounds).
module tb_game_phase_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        vsync_in;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        btn_menu;
    logic        btn_pause;
    logic        player_hit;
    logic        game_on;
    logic        menu_on;
    logic [2:0]  phase;
    logic [1:0]  countdown;
    logic [1:0]  pattern_sel;
    logic [7:0]  rounds_cleared;

    int n_assert = 0;
    int n_fail   = 0;

    game_phase_ctl #(
        .FRAMES_PER_SEC (2),
        .COUNTDOWN_SEC  (3),
        .ROUND_SEC      (2),
        .GAMEOVER_SEC   (2),
        .NUM_PATTERNS   (4),
        .DEBOUNCE_CYC   (4)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .vsync_in       (vsync_in),
        .xpos           (xpos),
        .ypos           (ypos),
        .mouse_left     (mouse_left),
        .btn_menu       (btn_menu),
        .btn_pause      (btn_pause),
        .player_hit     (player_hit),
        .game_on        (game_on),
        .menu_on        (menu_on),
        .phase          (phase),
        .countdown      (countdown),
        .pattern_sel    (pattern_sel),
        .rounds_cleared (rounds_cleared)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic vs();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
    endtask

    task automatic click_at(input logic [11:0] x, input logic [11:0] y);
        xpos       = x;
        ypos       = y;
        mouse_left = 1'b1;
        tick();
    endtask

    initial begin
        int menu_pulses;
        int game_pulses;

        rst = 1'b1; vsync_in = 1'b0; xpos = '0; ypos = '0;
        mouse_left = 1'b0; btn_menu = 1'b0; btn_pause = 1'b0; player_hit = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_phase", phase, 0);
        chk("rst_game_on", game_on, 0);
        chk("rst_menu_on", menu_on, 0);
        chk("rst_countdown", countdown, 0);
        chk("rst_pattern", pattern_sel, 0);
        chk("rst_rounds", rounds_cleared, 0);

        // Click outside the button, then drag a held button onto it.
        click_at(12'd100, 12'd100);
        chk("miss_phase", phase, 0);
        chk("miss_game_on", game_on, 0);
        xpos = 12'd500; ypos = 12'd450;
        repeat (3) tick();
        chk("held_phase", phase, 0);
        chk("held_game_on", game_on, 0);
        mouse_left = 1'b0;
        tick();

        // x exactly on the exclusive lower edge.
        click_at(12'd384, 12'd450);
        chk("edge_x_phase", phase, 0);
        mouse_left = 1'b0;
        tick();

        click_at(12'd500, 12'd450);
        chk("start_phase", phase, 1);
        chk("start_game_on", game_on, 1);
        chk("start_menu_on", menu_on, 0);
        chk("start_countdown", countdown, 3);
        mouse_left = 1'b0;
        tick();
        chk("start_game_on_drop", game_on, 0);

        vs(); chk("cd_e1", countdown, 3);
        vs(); chk("cd_e2", countdown, 2);
        vs(); chk("cd_e3", countdown, 2);
        vs(); chk("cd_e4", countdown, 1);
        vs(); chk("cd_e5_phase", phase, 1);
        vs();
        chk("cd_done_phase", phase, 2);
        chk("cd_done_count", countdown, 0);

        for (int r = 1; r <= 5; r++) begin
            repeat (4) vs();
            chk("round_pattern", pattern_sel, r % 4);
            chk("round_count", rounds_cleared, r);
        end
        chk("play_phase", phase, 2);

        // Hit lands on the vsync edge that would advance the pattern.
        repeat (3) vs();
        vsync_in   = 1'b1;
        player_hit = 1'b1;
        tick();
        chk("hit_phase", phase, 3);
        chk("hit_pattern", pattern_sel, 1);
        chk("hit_rounds", rounds_cleared, 5);
        vsync_in   = 1'b0;
        player_hit = 1'b0;
        tick();

        repeat (3) vs();
        chk("go_hold_phase", phase, 3);
        chk("go_hold_menu_on", menu_on, 0);
        vsync_in = 1'b1;
        tick();
        chk("go_exit_phase", phase, 0);
        chk("go_exit_menu_on", menu_on, 1);
        chk("go_exit_game_on", game_on, 0);
        chk("go_exit_pattern", pattern_sel, 1);
        vsync_in = 1'b0;
        tick();
        chk("go_menu_on_drop", menu_on, 0);

        // New game clears score, then bounce the menu button during PLAY.
        click_at(12'd690, 12'd480);
        chk("restart_phase", phase, 1);
        chk("restart_pattern", pattern_sel, 0);
        chk("restart_rounds", rounds_cleared, 0);
        mouse_left = 1'b0;
        tick();
        repeat (6) vs();
        chk("replay_phase", phase, 2);

        btn_menu = 1'b1; tick();
        btn_menu = 1'b0; tick();
        btn_menu = 1'b1; tick();
        menu_pulses = 0;
        game_pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (menu_on) menu_pulses++;
            if (game_on) game_pulses++;
        end
        chk("btn_menu_pulses", menu_pulses, 1);
        chk("btn_menu_game_on", game_pulses, 0);
        chk("btn_menu_phase", phase, 0);

        // Pressing the menu button again while already in MENU does nothing.
        btn_menu = 1'b0;
        repeat (12) tick();
        btn_menu = 1'b1;
        menu_pulses = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (menu_on) menu_pulses++;
        end
        chk("menu_in_menu_pulses", menu_pulses, 0);
        chk("menu_in_menu_phase", phase, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
